neuron_state_sequencer: RTL and testbench

Per-timestep controller that sits directly upstream and downstream of the membrane integrator. For every neuron it reads the stored membrane state and the accumulated stimulus, issues both to the integrator, and writes the integrator's output_new back to a local state memory. Spiking neuron indices go into an event FIFO for the routing stage. Owns the state memory; the top level drives the integrator's decay, threshold and detection directly.

---
 rtl/neuron_state_sequencer.sv | 163 ++++++++++++++++
 tb/tb_neuron_state_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_state_sequencer.sv
// Per-timestep sequencer around the membrane integrator: state memory, issue/write-back, spike event FIFO.
// Optional build macro SEQ_SPIKE_COUNT_EN adds a per-step spike_count output.
module neuron_state_sequencer #(
  parameter int WIDTH      = 20,
  parameter int N_NEURONS  = 256,
  parameter int IDX_W      = 8,
  parameter int INT_LAT    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_start,
  input  logic             step_start,
  output logic             busy,
  output logic             step_done,
  output logic             stim_rd,
  output logic [IDX_W-1:0] stim_addr,
  input  logic [WIDTH-1:0] stim_data,
  output logic             int_en,
  output logic [WIDTH-1:0] int_output_old,
  output logic [WIDTH-1:0] int_stimolo,
  input  logic             int_valid,
  input  logic             int_spike,
  input  logic [WIDTH-1:0] int_output_new,
  output logic             spk_valid,
  input  logic             spk_ready,
  output logic [IDX_W-1:0] spk_idx
`ifdef SEQ_SPIKE_COUNT_EN
  ,
  output logic [IDX_W:0]   spike_count
`endif
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(INT_LAT + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  logic [2:0]       state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [CW-1:0]    credits_reg, credits_next;
  logic [FW-1:0]    inflight_reg, inflight_next;

  logic [WIDTH-1:0] mem [N_NEURONS];
  logic [WIDTH-1:0] rd_data_reg;

  logic [INT_LAT:0]              dl_valid_reg;
  logic [INT_LAT:0][IDX_W-1:0]   dl_idx_reg;

  logic [IDX_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0]      wr_ptr_reg, rd_ptr_reg;

  logic             issue, retire, wb, push, pop, clear_we, mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;

  assign issue  = (state_reg == ISSUE) && (credits_reg != '0);
  // An index leaving the delay line always retires, even if int_valid failed to show, so DRAIN cannot hang.
  assign retire = dl_valid_reg[INT_LAT];
  assign wb     = retire && int_valid;
  assign push   = wb && int_spike;
  assign pop    = spk_valid && spk_ready;

  assign inflight_next = inflight_reg + FW'(issue) - FW'(retire);
  assign credits_next  = credits_reg - CW'(issue) + CW'(retire && !push) + CW'(pop);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (clear_start) begin
          state_next = CLEAR;
          idx_next   = '0;
        end else if (step_start) begin
          state_next = ISSUE;
          idx_next   = '0;
        end
      end
      CLEAR: begin
        idx_next = idx_reg + IDX_W'(1);
        if (idx_reg == LAST_IDX) state_next = DONE;
      end
      ISSUE: begin
        if (issue) begin
          idx_next = idx_reg + IDX_W'(1);
          if (idx_reg == LAST_IDX) state_next = DRAIN;
        end
      end
      DRAIN:   if (inflight_next == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      credits_reg  <= CW'(FIFO_DEPTH);
      inflight_reg <= '0;
      dl_valid_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      credits_reg  <= credits_next;
      inflight_reg <= inflight_next;
      dl_valid_reg <= {dl_valid_reg[INT_LAT-1:0], issue};
      wr_ptr_reg   <= wr_ptr_reg + (PW+1)'(push);
      rd_ptr_reg   <= rd_ptr_reg + (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    dl_idx_reg <= {dl_idx_reg[INT_LAT-1:0], idx_reg};
  end

  // Single write port shared by the clear sweep and write-back; the two never overlap in time.
  assign clear_we  = (state_reg == CLEAR);
  assign mem_we    = (clear_we || wb) && !rst;
  assign mem_addr  = clear_we ? idx_reg : dl_idx_reg[INT_LAT];
  assign mem_wdata = clear_we ? '0 : int_output_new;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (issue)  rd_data_reg   <= mem[idx_reg];
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[PW-1:0]] <= dl_idx_reg[INT_LAT];
  end

  assign spk_valid = (wr_ptr_reg != rd_ptr_reg);
  assign spk_idx   = spk_valid ? fifo_mem[rd_ptr_reg[PW-1:0]] : '0;

  assign busy           = (state_reg != IDLE);
  assign step_done      = (state_reg == DONE);
  assign stim_rd        = issue;
  assign stim_addr      = issue ? idx_reg : '0;
  assign int_en         = dl_valid_reg[0];
  assign int_output_old = int_en ? rd_data_reg : '0;
  assign int_stimolo    = int_en ? stim_data : '0;

`ifdef SEQ_SPIKE_COUNT_EN
  logic [IDX_W:0] spike_count_reg;

  always_ff @(posedge clk) begin
    if (rst)                                                     spike_count_reg <= '0;
    else if ((state_reg == IDLE) && step_start && !clear_start) spike_count_reg <= '0;
    else if (push)                                               spike_count_reg <= spike_count_reg + (IDX_W+1)'(1);
  end

  assign spike_count = spike_count_reg;
`endif

endmodule

// File: tb/tb_neuron_state_sequencer.sv
// Self-checking bench for neuron_state_sequencer: per-neuron step model, behavioural integrator, random stimulus.
module tb_neuron_state_sequencer;
  localparam int WIDTH = 20, N = 16, IDX_W = 4, INT_LAT = 4, FD = 8;
  localparam int THR_NEVER = 1 << 20;

  logic clk = 1'b0;
  logic rst = 1'b1, clear_start = 1'b0, step_start = 1'b0;
  logic busy, step_done, stim_rd, int_en, spk_valid;
  logic spk_ready = 1'b1;
  logic [IDX_W-1:0] stim_addr, spk_idx;
  logic [WIDTH-1:0] stim_data = '0, int_output_old, int_stimolo, int_output_new = '0;
  logic int_valid = 1'b0, int_spike = 1'b0;
`ifdef SEQ_SPIKE_COUNT_EN
  logic [IDX_W:0] spike_count;
`endif

  always #5 clk = ~clk;

  neuron_state_sequencer #(.WIDTH(WIDTH), .N_NEURONS(N), .IDX_W(IDX_W), .INT_LAT(INT_LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .clear_start(clear_start), .step_start(step_start),
    .busy(busy), .step_done(step_done), .stim_rd(stim_rd), .stim_addr(stim_addr), .stim_data(stim_data),
    .int_en(int_en), .int_output_old(int_output_old), .int_stimolo(int_stimolo),
    .int_valid(int_valid), .int_spike(int_spike), .int_output_new(int_output_new),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_idx(spk_idx)
`ifdef SEQ_SPIKE_COUNT_EN
    , .spike_count(spike_count)
`endif
  );

  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  int done_cnt = 0, n_issue = 0, outstanding = 0;
  bit ready_rand = 0;
  int decay = 0, thr = THR_NEVER, step_spikes = 0;
  int stim_mem [N];
  int ref_mem [N];
  int ref_bak [N];
  int exp_old_q [$];
  int exp_stim_q [$];
  int exp_evt_q [$];
  // behavioural integrator pipeline (entries flagged stale were flushed from the DUT by rst)
  bit pv [INT_LAT] = '{default: 0};
  bit ps [INT_LAT] = '{default: 0};
  bit pst [INT_LAT] = '{default: 0};
  int pn [INT_LAT] = '{default: 0};
  bit cur_stale = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void integ(input int old, input int stim, output int nv, output bit s);
    longint v;
    v = ((longint'(old) * decay) >>> 12) + (longint'(stim) <<< 5);
    if (v > 64'h000F_FFFF) v = 64'h000F_FFFF;
    s  = (v >= thr);
    nv = s ? 0 : int'(v);
  endfunction

  // One clock cycle: observe at negedge, then drive the next cycle's inputs just after posedge.
  task automatic cycle();
    int nv, next_stim;
    bit s;
    @(negedge clk);
    if (step_done) done_cnt++;
    if (int_en) begin
      n_issue++;
      outstanding++;
      check("issue_expected", exp_old_q.size() != 0, 1);
      if (exp_old_q.size() != 0) begin
        check("int_output_old", int_output_old, exp_old_q.pop_front());
        check("int_stimolo", int_stimolo, exp_stim_q.pop_front());
      end
    end
    if (int_valid && !int_spike && !cur_stale) outstanding--;
    if (spk_valid && spk_ready) begin
      outstanding--;
      check("event_expected", exp_evt_q.size() != 0, 1);
      if (exp_evt_q.size() != 0) check("spk_idx", spk_idx, exp_evt_q.pop_front());
    end
    check("credit_bound", outstanding <= FD, 1);
    integ(int'(int_output_old), int'(int_stimolo), nv, s);
    for (int j = INT_LAT - 1; j > 0; j--) begin
      pv[j] = pv[j-1]; ps[j] = ps[j-1]; pn[j] = pn[j-1]; pst[j] = pst[j-1];
    end
    pv[0] = int_en; ps[0] = s; pn[0] = nv; pst[0] = 1'b0;
    if (rst) begin
      for (int j = 0; j < INT_LAT; j++) pst[j] = 1'b1;
      outstanding = 0;
    end
    next_stim = stim_rd ? stim_mem[stim_addr] : 0;
    @(posedge clk);
    #1;
    stim_data      = WIDTH'(next_stim);
    int_valid      = pv[INT_LAT-1];
    int_spike      = pv[INT_LAT-1] && ps[INT_LAT-1];
    int_output_new = pv[INT_LAT-1] ? WIDTH'(pn[INT_LAT-1]) : '0;
    cur_stale      = pst[INT_LAT-1];
    step_start     = 1'b0;
    clear_start    = 1'b0;
    if (ready_rand) spk_ready = 1'($urandom_range(0, 1));
  endtask

  // Expected issue pairs, state updates and events for one full timestep.
  task automatic model_step();
    int nv;
    bit s;
    step_spikes = 0;
    for (int i = 0; i < N; i++) begin
      exp_old_q.push_back(ref_mem[i]);
      exp_stim_q.push_back(stim_mem[i]);
      integ(ref_mem[i], stim_mem[i], nv, s);
      ref_mem[i] = nv;
      if (s) begin
        exp_evt_q.push_back(i);
        step_spikes++;
      end
    end
  endtask

  task automatic set_stim_random();
    for (int i = 0; i < N; i++) stim_mem[i] = $urandom_range(0, 63);
  endtask

  task automatic wait_done(input int max_cyc, output int lat);
    int d0;
    d0  = done_cnt;
    lat = 0;
    do begin
      cycle();
      lat++;
    end while (done_cnt == d0 && lat < max_cyc);
    check("step_done_seen", done_cnt - d0, 1);
    lat = lat - 1;
  endtask

  task automatic run_step(input bit check_lat);
    int lat;
    model_step();
    step_start = 1'b1;
    wait_done(400, lat);
    if (check_lat) check("step_latency", lat, N + INT_LAT + 2);
    check("issues_complete", exp_old_q.size(), 0);
  endtask

  task automatic drain_events();
    int k;
    bit rr;
    rr = ready_rand;
    ready_rand = 0;
    spk_ready = 1'b1;
    k = 0;
    while (exp_evt_q.size() != 0 && k < 200) begin
      cycle();
      k++;
    end
    cycle();
    check("events_drained", exp_evt_q.size(), 0);
    check("spk_valid_empty", spk_valid, 0);
    ready_rand = rr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, d0, n0;
    for (int i = 0; i < N; i++) begin stim_mem[i] = 0; ref_mem[i] = 0; end

    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_step_done", step_done, 0);
    check("rst_spk_valid", spk_valid, 0);
    check("rst_int_en", int_en, 0);
    check("rst_stim_rd", stim_rd, 0);
    check("rst_int_output_old", int_output_old, 0);
`ifdef SEQ_SPIKE_COUNT_EN
    check("rst_spike_count", spike_count, 0);
`endif

    clear_start = 1'b1;
    wait_done(400, lat);
    check("clear_latency", lat, N + 1);
    for (int i = 0; i < N; i++) ref_mem[i] = 0;

    decay = 0; thr = THR_NEVER;
    run_step(1);
    check("quiet_spk_valid", spk_valid, 0);

    decay = 2048; thr = 100;
    for (int i = 0; i < N; i++) stim_mem[i] = 2;
    for (int s = 0; s < 3; s++) begin
      run_step(1);
`ifdef SEQ_SPIKE_COUNT_EN
      check("spike_count", spike_count, step_spikes);
`endif
    end
    drain_events();

    ready_rand = 1;
    repeat (6) begin
      decay = $urandom_range(0, 4095);
      thr   = $urandom_range(300, 3000);
      set_stim_random();
      run_step(0);
    end
    drain_events();
    ready_rand = 0;

    // Every neuron spikes with no consumer: issue must stop when the FIFO credits run out.
    thr = 0;
    set_stim_random();
    model_step();
    spk_ready = 1'b0;
    n0 = n_issue;
    step_start = 1'b1;
    repeat (40) cycle();
    check("stall_issue_count", n_issue - n0, FD);
    check("stall_busy", busy, 1);
    spk_ready = 1'b1;
    wait_done(400, lat);
    drain_events();
    check("stall_issues_complete", exp_old_q.size(), 0);

    thr = THR_NEVER;
    decay = $urandom_range(0, 4095);
    set_stim_random();
    model_step();
    d0 = done_cnt;
    n0 = n_issue;
    step_start = 1'b1;
    repeat (4) cycle();
    step_start = 1'b1;
    cycle();
    clear_start = 1'b1;
    wait_done(400, lat);
    repeat (N + 10) cycle();
    check("busy_pulse_done_count", done_cnt - d0, 1);
    check("busy_pulse_issues", n_issue - n0, N);
    check("busy_pulse_idle", busy, 0);

    n0 = n_issue;
    clear_start = 1'b1;
    step_start  = 1'b1;
    wait_done(400, lat);
    check("clear_prio_latency", lat, N + 1);
    repeat (N + 10) cycle();
    check("clear_prio_no_issue", n_issue - n0, 0);
    for (int i = 0; i < N; i++) ref_mem[i] = 0;
    set_stim_random();
    run_step(1);

    // Reset in the third ISSUE cycle: nothing has been written back yet, so memory must be untouched.
    for (int i = 0; i < N; i++) ref_bak[i] = ref_mem[i];
    decay = $urandom_range(0, 4095);
    thr   = $urandom_range(300, 3000);
    set_stim_random();
    model_step();
    step_start = 1'b1;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_spk_valid", spk_valid, 0);
    check("midrst_int_en", int_en, 0);
    for (int i = 0; i < N; i++) ref_mem[i] = ref_bak[i];
    exp_old_q.delete();
    exp_stim_q.delete();
    exp_evt_q.delete();
    set_stim_random();
    run_step(0);
    drain_events();
    run_step(0);
    drain_events();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
